// File: rtl/cpu_status_seq_if.sv
// Handshake and STATUS-load bundle between the flag/bus requesters and cpu_status_seq.
// master = requester side (drives requests and status_in), slave = sequencer.
interface cpu_status_seq_if;
    logic       stall;
    logic       alu_req;
    logic [2:0] alu_flags;
    logic [2:0] alu_flag_mask;
    logic       bus_req;
    logic [7:0] bus_data;
    logic [7:0] status_in;
    logic [7:0] alu_to_status;
    logic [2:0] status_bus;
    logic       load_status_reg;
    logic       status_c_load;
    logic       status_dc_load;
    logic       status_z_load;
    logic       alu_ack;
    logic       bus_ack;
    logic [1:0] q_phase;

    modport master (
        output stall, alu_req, alu_flags, alu_flag_mask, bus_req, bus_data, status_in,
        input  alu_to_status, status_bus, load_status_reg, status_c_load, status_dc_load,
               status_z_load, alu_ack, bus_ack, q_phase
    );

    modport slave (
        input  stall, alu_req, alu_flags, alu_flag_mask, bus_req, bus_data, status_in,
        output alu_to_status, status_bus, load_status_reg, status_c_load, status_dc_load,
               status_z_load, alu_ack, bus_ack, q_phase
    );
endinterface

// File: rtl/cpu_status_seq.sv
// Q1..Q4 sequencer merging ALU flag updates and bus writes into STATUS load strobes in Q4.
// Optional macro STATUS_TOPD_PROTECT_EN keeps TO/PD (bits 4:3) read-only on bus writes.
module cpu_status_seq (
    input  logic            clk,
    input  logic            rst,
    cpu_status_seq_if.slave sif
);
    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

`ifdef STATUS_TOPD_PROTECT_EN
    localparam logic [7:0] PROTECT_MASK = 8'h18;
`else
    localparam logic [7:0] PROTECT_MASK = 8'h00;
`endif

    function automatic logic [7:0] merge_status(input logic [7:0] wr, input logic [7:0] cur);
        return (wr & ~PROTECT_MASK) | (cur & PROTECT_MASK);
    endfunction

    phase_t     phase, phase_nxt;
    logic       alu_cap, bus_cap;
    logic [2:0] flags_cap_p0, mask_cap_p0;
    logic [7:0] data_cap_p0;
    logic       alu_take, bus_take, alu_eff, bus_eff, alu_merge;
    logic [2:0] flags_eff, mask_eff;
    logic [7:0] data_eff;
    logic       load_nxt;
    logic [7:0] ats_nxt;
    logic [2:0] sbus_nxt, loads_nxt;
    logic       load_p1, alu_ack_p1, bus_ack_p1;
    logic [7:0] ats_p1;
    logic [2:0] sbus_p1, loads_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phase <= Q1;
        else      phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = phase;
        if (!sif.stall) begin
            case (phase)
                Q1:      phase_nxt = Q2;
                Q2:      phase_nxt = Q3;
                Q3:      phase_nxt = Q4;
                default: phase_nxt = Q1;
            endcase
        end
    end

    // A request seen on the Q3->Q4 edge itself still counts, so the Q4 result
    // is formed from captured values or, if not yet captured, the live inputs.
    always_comb begin
        alu_take  = sif.alu_req && !alu_cap && (phase != Q4) && !sif.stall;
        bus_take  = sif.bus_req && !bus_cap && (phase != Q4) && !sif.stall;
        alu_eff   = alu_cap || alu_take;
        bus_eff   = bus_cap || bus_take;
        flags_eff = alu_cap ? flags_cap_p0 : sif.alu_flags;
        mask_eff  = alu_cap ? mask_cap_p0  : sif.alu_flag_mask;
        data_eff  = bus_cap ? data_cap_p0  : sif.bus_data;
        alu_merge = alu_eff && (mask_eff != 3'b000);
        load_nxt  = bus_eff;
        ats_nxt   = bus_eff ? merge_status(data_eff, sif.status_in) : 8'h00;
        sbus_nxt  = (alu_merge || (alu_eff && !bus_eff)) ? flags_eff : 3'b000;
        loads_nxt = alu_merge ? mask_eff : 3'b000;
    end

    // ---- stage p0: request capture (Q1..Q3) / stage p1: Q4 strobes ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_cap    <= 1'b0;
            bus_cap    <= 1'b0;
            load_p1    <= 1'b0;
            ats_p1     <= 8'h00;
            sbus_p1    <= 3'b000;
            loads_p1   <= 3'b000;
            alu_ack_p1 <= 1'b0;
            bus_ack_p1 <= 1'b0;
        end else if (!sif.stall) begin
            if (phase == Q4) begin
                alu_cap    <= 1'b0;
                bus_cap    <= 1'b0;
                load_p1    <= 1'b0;
                ats_p1     <= 8'h00;
                sbus_p1    <= 3'b000;
                loads_p1   <= 3'b000;
                alu_ack_p1 <= 1'b0;
                bus_ack_p1 <= 1'b0;
            end else begin
                if (alu_take) alu_cap <= 1'b1;
                if (bus_take) bus_cap <= 1'b1;
                if (phase == Q3) begin
                    load_p1    <= load_nxt;
                    ats_p1     <= ats_nxt;
                    sbus_p1    <= sbus_nxt;
                    loads_p1   <= loads_nxt;
                    alu_ack_p1 <= alu_eff;
                    bus_ack_p1 <= bus_eff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alu_take) begin
            flags_cap_p0 <= sif.alu_flags;
            mask_cap_p0  <= sif.alu_flag_mask;
        end
        if (bus_take) data_cap_p0 <= sif.bus_data;
    end

    assign sif.q_phase         = phase;
    assign sif.load_status_reg = load_p1;
    assign sif.alu_to_status   = ats_p1;
    assign sif.status_bus      = sbus_p1;
    assign sif.status_c_load   = loads_p1[0];
    assign sif.status_dc_load  = loads_p1[1];
    assign sif.status_z_load   = loads_p1[2];
    assign sif.alu_ack         = alu_ack_p1;
    assign sif.bus_ack         = bus_ack_p1;
endmodule

// File: tb/tb_cpu_status_seq.sv
// Scoreboard bench for cpu_status_seq: each instruction cycle queues its expected Q4 result,
// a negedge monitor pops and compares on Q4 entry and checks strobes stay low elsewhere.
module tb_cpu_status_seq;
    typedef struct packed {
        logic       load;
        logic [7:0] ats;
        logic [2:0] sbus;
        logic       z, dc, c;
        logic       aack, back;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    cpu_status_seq_if sif ();
    cpu_status_seq dut (.clk(clk), .rst(rst), .sif(sif));

    always #5 clk = ~clk;

`ifdef STATUS_TOPD_PROTECT_EN
    localparam logic [7:0] A5_EXP = 8'hBD;
`else
    localparam logic [7:0] A5_EXP = 8'hA5;
`endif

    function automatic exp_t mk(input logic load, input logic [7:0] ats, input logic [2:0] sbus,
                                input logic z, input logic dc, input logic c,
                                input logic aack, input logic back);
        exp_t e;
        e.load = load; e.ats = ats; e.sbus = sbus;
        e.z = z; e.dc = dc; e.c = c; e.aack = aack; e.back = back;
        return e;
    endfunction

    function automatic exp_t actual();
        return mk(sif.load_status_reg, sif.alu_to_status, sif.status_bus, sif.status_z_load,
                  sif.status_dc_load, sif.status_c_load, sif.alu_ack, sif.bus_ack);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: Q4 entry pops the next expectation; stalled Q4 cycles must hold it.
    bit   in_q4 = 1'b0;
    exp_t cur = '0;
    always @(negedge clk) begin
        if (sif.q_phase == 2'd3) begin
            if (!in_q4) begin
                in_q4 = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL q4_unexpected: got Q4 with no queued expectation (t=%0t)", $time);
                    cur = actual();
                end else begin
                    cur = sb.pop_front();
                    chk("q4_result", 32'(actual()), 32'(cur));
                end
            end else begin
                chk("q4_hold", 32'(actual()), 32'(cur));
            end
        end else begin
            in_q4 = 1'b0;
            chk("idle_strobes", 32'({sif.load_status_reg, sif.status_c_load, sif.status_dc_load,
                                     sif.status_z_load, sif.alu_ack, sif.bus_ack}), 32'd0);
        end
    end

    // One instruction cycle, entered in Q1 before the Q1->Q2 edge. Phase args of -1 mean unused.
    task automatic inst(input string nm, input exp_t e,
                        input int bus_ph, input logic [7:0] bdata, input int chg_ph,
                        input int alu_ph, input logic [2:0] flags, input logic [2:0] mask,
                        input int stall_ph, input int stall_n);
        sb.push_back(e);
        for (int p = 0; p < 4; p++) begin
            chk({nm, "_phase"}, 32'(sif.q_phase), 32'(p));
            if (p == 3) begin
                if (sif.alu_ack) sif.alu_req = 1'b0;
                if (sif.bus_ack) sif.bus_req = 1'b0;
            end
            if (p == bus_ph) begin
                sif.bus_req = 1'b1; sif.bus_data = bdata;
            end
            if (p == alu_ph) begin
                sif.alu_req = 1'b1; sif.alu_flags = flags; sif.alu_flag_mask = mask;
            end
            if (p == chg_ph) sif.bus_data = ~sif.bus_data;
            if (p == stall_ph) begin
                sif.stall = 1'b1;
                for (int k = 0; k < stall_n; k++) begin
                    step();
                    chk({nm, "_stall_phase"}, 32'(sif.q_phase), 32'(p));
                end
                sif.stall = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.stall = 1'b0; sif.alu_req = 1'b0; sif.alu_flags = 3'b000; sif.alu_flag_mask = 3'b000;
        sif.bus_req = 1'b0; sif.bus_data = 8'h00; sif.status_in = 8'h18;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("reset_phase", 32'(sif.q_phase), 32'd0);
        chk("reset_outputs", 32'(actual()), 32'd0);
        #18 rst = 1'b1;

        inst("idle0", mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 0), -1, 8'h00, -1, -1, 3'b000, 3'b000, -1, 0);
        inst("bus_a5", mk(1, A5_EXP, 3'b000, 0, 0, 0, 0, 1), 0, 8'hA5, -1, -1, 3'b000, 3'b000, -1, 0);
        inst("alu_101", mk(0, 8'h00, 3'b101, 1, 0, 1, 1, 0), -1, 8'h00, -1, 0, 3'b101, 3'b101, -1, 0);
        inst("both_q2", mk(1, 8'hFF, 3'b000, 1, 0, 0, 1, 1), 1, 8'hFF, -1, 1, 3'b000, 3'b100, -1, 0);
        inst("both_mask0", mk(1, 8'h3C, 3'b000, 0, 0, 0, 1, 1), 0, 8'h3C, -1, 0, 3'b111, 3'b000, -1, 0);
        inst("alu_mask0_q3", mk(0, 8'h00, 3'b000, 0, 0, 0, 1, 0), -1, 8'h00, -1, 2, 3'b000, 3'b000, -1, 0);
        inst("both_late_chg", mk(1, 8'h3C, 3'b110, 0, 1, 0, 1, 1), 0, 8'h3C, 1, 1, 3'b110, 3'b010, -1, 0);
        inst("alu_in_q4", mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 0), -1, 8'h00, -1, 3, 3'b011, 3'b011, -1, 0);
        inst("alu_deferred", mk(0, 8'h00, 3'b011, 0, 1, 1, 1, 0), -1, 8'h00, -1, -1, 3'b000, 3'b000, -1, 0);
        inst("stall_q3", mk(1, 8'h5A, 3'b000, 0, 0, 0, 0, 1), 0, 8'h5A, -1, -1, 3'b000, 3'b000, 2, 3);
        inst("stall_q4", mk(0, 8'h00, 3'b100, 1, 1, 1, 1, 0), -1, 8'h00, -1, 0, 3'b100, 3'b111, 3, 2);
        inst("idle1", mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 0), -1, 8'h00, -1, -1, 3'b000, 3'b000, -1, 0);

        // Reset in Q3 with a captured bus write: dropped, never acknowledged.
        sif.bus_req = 1'b1; sif.bus_data = 8'h81;
        step(); step();
        chk("rstq3_pre_phase", 32'(sif.q_phase), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("rstq3_async_phase", 32'(sif.q_phase), 32'd0);
        chk("rstq3_async_outputs", 32'(actual()), 32'd0);
        sif.bus_req = 1'b0;
        step();
        chk("rstq3_hold_phase", 32'(sif.q_phase), 32'd0);
        rst = 1'b1;
        inst("after_rstq3", mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 0), -1, 8'h00, -1, -1, 3'b000, 3'b000, -1, 0);

        // Reset inside Q4 drops live strobes immediately.
        sif.bus_req = 1'b1; sif.bus_data = 8'h5A;
        step(); step(); step();
        chk("rstq4_pre_strobes", 32'({sif.load_status_reg, sif.bus_ack}), 32'd3);
        #1 rst = 1'b0;
        #1;
        chk("rstq4_async_phase", 32'(sif.q_phase), 32'd0);
        chk("rstq4_async_outputs", 32'(actual()), 32'd0);
        sif.bus_req = 1'b0;
        step();
        rst = 1'b1;
        inst("after_rstq4", mk(0, 8'h00, 3'b000, 0, 0, 0, 0, 0), -1, 8'h00, -1, -1, 3'b000, 3'b000, -1, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_status_seq.md
CPU_STATUS_SEQ -- requirements
Module: cpu_status_seq

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state changes on posedge.
REQ-002 SHALL: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL: stall  in  1  high freezes phase counter and captured requests.
REQ-004 SHALL: alu_req  in  1  ALU requests flag update; held until alu_ack.
REQ-005 SHALL: alu_flags  in  3  new {Z,DC,C} values, bit order matching status bits 2:0.
REQ-006 SHALL: alu_flag_mask  in  3  per-flag update enable for C, DC, Z.
REQ-007 SHALL: bus_req  in  1  file-register write to STATUS; held until bus_ack.
REQ-008 SHALL: bus_data  in  8  byte written to STATUS.
REQ-009 SHALL: status_in  in  8  current status register value.
REQ-010 SHALL: alu_to_status  out  8  full-byte load data to status register.
REQ-011 SHALL: status_bus  out  3  per-flag load data.
REQ-012 SHALL: load_status_reg, status_c_load, status_dc_load, status_z_load  out  1 each  status register load strobes.
REQ-013 SHALL: alu_ack, bus_ack  out  1 each  one-cycle completion pulses.
REQ-014 SHALL: q_phase  out  2  current instruction phase, 0=Q1 .. 3=Q4.

Function
REQ-015 SHALL: 2-bit phase counter advance Q1->Q2->Q3->Q4->Q1 each clk while stall=0; hold while stall=1.
REQ-016 SHALL: capture alu_req/bus_req and their data on the first clk edge seen high while phase is Q1, Q2 or Q3; later data changes ignored until ack.
REQ-017 SHALL: requests first seen during Q4 not captured; captured in next instruction cycle's Q1-Q3 window.
REQ-018 SHALL: on Q3->Q4 edge, register all strobes/data; strobes high for exactly the Q4 cycle, low otherwise.
REQ-019 SHALL: bus only: load_status_reg=1, alu_to_status=captured bus_data, per-flag loads=0.
REQ-020 SHALL: ALU only: load_status_reg=0, status_bus=alu_flags, status_c/dc/z_load=alu_flag_mask bits.
REQ-021 SHALL: both same cycle, mask nonzero: load_status_reg=1, alu_to_status=bus_data, status_bus=alu_flags, per-flag loads=mask; unmasked C/DC/Z retain old value.
REQ-022 SHALL: both same cycle, mask zero: behave as bus only.
REQ-023 SHALL: ALU only, mask zero: no strobes asserted; alu_ack still pulses.
REQ-024 SHALL: alu_ack/bus_ack pulse during Q4 for each captured request; captured flags clear on the Q4->Q1 edge.
REQ-025 SHALL: stall high in Q3 defers Q4 entry; stall high in Q4 holds strobes/acks high until stall releases (status load idempotent).
REQ-026 SHALL: no request captured -> Q4 with all strobes and acks low.

Reset
REQ-027 SHALL: rst low immediately forces q_phase=0, all strobes, acks, alu_to_status, status_bus to 0, and clears captured requests.
REQ-028 SHALL: reset mid-cycle drops captured requests without ack; requesters re-present after release.
REQ-029 SHALL: first phase after rst release is Q1; first advance on the first clk edge with rst high.

Configuration
REQ-030 SHALL: macro STATUS_TOPD_PROTECT_EN defined: alu_to_status bits 4:3 = status_in bits 4:3 on any bus write (TO/PD not writable).
REQ-031 SHALL: macro undefined: alu_to_status = bus_data on all 8 bits.

Verification
REQ-032 SHALL: bus_req, bus_data=0xA5 at Q1 -> Q4: load_status_reg=1, alu_to_status=0xA5 (0xBD with macro, status_in=0x18), bus_ack=1.
REQ-033 SHALL: alu_req, flags=3'b101, mask=3'b101 -> Q4: status_bus=101, c_load=1, dc_load=0, z_load=1, load_status_reg=0.
REQ-034 SHALL: both at Q2, bus_data=0xFF, flags=000, mask=100 -> Q4: load_status_reg=1, z_load=1, status_bus=000, both acks.
REQ-035 SHALL: alu_req first raised in Q4 -> no strobe that cycle; served in following Q4, ack 4 clks later.
REQ-036 SHALL: stall held 3 clks in Q3 -> q_phase stays 2, Q4 strobes delayed exactly 3 clks.
REQ-037 SHALL: rst low during Q3 with captured bus_req -> outputs 0 asynchronously, no bus_ack, phase Q1 after release.
